// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage arithmetic units.
// Holds the divider state encoding and default operand width.
package mips_pkg;

   localparam int DIV_N = 16;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   function automatic int div_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/divisor_passo.sv
// One combinational restoring-division step: shift the partial remainder
// left by one quotient bit, subtract the divisor if it fits, record the bit.
module divisor_passo #(
   parameter int N = 16
) (
   input  logic [N-1:0] r,
   input  logic [N-1:0] q,
   input  logic [N-1:0] d2,
   output logic [N-1:0] r_next,
   output logic [N-1:0] q_next
);

   logic [N-1:0] shifted;
   logic [N-1:0] diff;
   logic         fits;

   // The shifted remainder is N+1 bits wide, but since R < D2 the difference
   // always fits back in N bits, so the subtraction can run modulo 2^N.
   assign shifted = {r[N-2:0], q[N-1]};
   assign fits    = ({r, q[N-1]} >= {1'b0, d2});
   assign diff    = shifted - d2;

   always_comb begin
      r_next = shifted;
      q_next = {q[N-2:0], 1'b0};
      if (fits) begin
         r_next = diff;
         q_next = {q[N-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divisor.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per clock, results held until the next accepted start.
module divisor
   import mips_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           St,
   input  logic [2*N-1:0] D1,
   input  logic [N-1:0]   D2,
   output logic [N-1:0]   quoc,
   output logic [N-1:0]   rest,
   output logic           Busy,
   output logic           Done,
   output logic           Ovf
);

   localparam int CW = div_cnt_w(N);

   div_state_t     state_reg, state_next;
   logic [N-1:0]   r_reg, r_next;
   logic [N-1:0]   q_reg, q_next;
   logic [N-1:0]   d2_reg, d2_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [N-1:0]   quoc_reg, quoc_next;
   logic [N-1:0]   rest_reg, rest_next;
   logic           busy_reg, busy_next;
   logic           done_reg, done_next;
   logic           ovf_reg, ovf_next;

   logic [N-1:0]   step_r, step_q;

   divisor_passo #(.N(N)) u_passo (
      .r      (r_reg),
      .q      (q_reg),
      .d2     (d2_reg),
      .r_next (step_r),
      .q_next (step_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= DIV_IDLE;
         r_reg     <= '0;
         q_reg     <= '0;
         d2_reg    <= '0;
         cnt_reg   <= '0;
         quoc_reg  <= '0;
         rest_reg  <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         q_reg     <= q_next;
         d2_reg    <= d2_next;
         cnt_reg   <= cnt_next;
         quoc_reg  <= quoc_next;
         rest_reg  <= rest_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      q_next     = q_reg;
      d2_next    = d2_reg;
      cnt_next   = cnt_reg;
      quoc_next  = quoc_reg;
      rest_next  = rest_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      ovf_next   = ovf_reg;

      unique case (state_reg)
         DIV_IDLE: begin
            if (St) begin
               d2_next  = D2;
               r_next   = D1[2*N-1:N];
               q_next   = D1[N-1:0];
               cnt_next = '0;
               ovf_next = 1'b0;
               // A high half >= divisor means the quotient needs more than N bits.
               if (D2 == '0 || D1[2*N-1:N] >= D2) begin
                  state_next = DIV_DONE;
                  ovf_next   = 1'b1;
                  quoc_next  = '1;
                  rest_next  = '0;
                  done_next  = 1'b1;
               end else begin
                  state_next = DIV_CALC;
                  busy_next  = 1'b1;
               end
            end
         end
         DIV_CALC: begin
            r_next   = step_r;
            q_next   = step_q;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CW'(N - 1)) begin
               quoc_next  = step_q;
               rest_next  = step_r;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = DIV_DONE;
            end
         end
         DIV_DONE: begin
            state_next = DIV_IDLE;
         end
         default: begin
            state_next = DIV_IDLE;
         end
      endcase
   end

   assign quoc = quoc_reg;
   assign rest = rest_reg;
   assign Busy = busy_reg;
   assign Done = done_reg;
   assign Ovf  = ovf_reg;

endmodule

// File: tb/tb_divisor.sv
// Scoreboard bench for the divider: stimulus pushes expected results from an
// arithmetic reference model, a monitor pops and compares on every Done pulse.
module tb_divisor;

   localparam int N = 16;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        St  = 1'b0;
   logic [31:0] D1  = '0;
   logic [15:0] D2  = '0;
   logic [15:0] quoc, rest;
   logic        Busy, Done, Ovf;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   divisor #(.N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .St   (St),
      .D1   (D1),
      .D2   (D2),
      .quoc (quoc),
      .rest (rest),
      .Busy (Busy),
      .Done (Done),
      .Ovf  (Ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [31:0] d1, input logic [15:0] d2);
      exp_t            e;
      longint unsigned a, b, qq, rr;
      a = longint'(d1);
      b = longint'(d2);
      e.q = '1; e.r = '0; e.ovf = 1'b1;
      if (b != 0) begin
         qq = a / b;
         rr = a % b;
         if (qq <= 64'd65535) begin
            e.q   = qq[15:0];
            e.r   = rr[15:0];
            e.ovf = 1'b0;
         end
      end
      return e;
   endfunction

   // Monitor: compares every result the DUT presents against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst && Done) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got Done with empty scoreboard, expected no Done");
         end else begin
            e = exp_q.pop_front();
            $display("[TB] result quoc=0x%04h rest=0x%04h ovf=%0b (exp 0x%04h 0x%04h %0b)",
                     quoc, rest, Ovf, e.q, e.r, e.ovf);
            chk("quoc", 32'(quoc), 32'(e.q));
            chk("rest", 32'(rest), 32'(e.r));
            chk("ovf", 32'(Ovf), 32'(e.ovf));
            chk("busy_at_done", 32'(Busy), 32'd0);
         end
      end
   end

   // Issue one start pulse and check Done latency and Busy duration.
   task automatic run_div(input logic [31:0] d1, input logic [15:0] d2);
      exp_t        e;
      int          k, busy_cnt, done_at;
      logic [31:0] junk;
      e = model(d1, d2);
      @(negedge clk);
      D1 = d1; D2 = d2; St = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      St = 1'b0;
      junk = $urandom; D1 = junk;
      junk = $urandom; D2 = junk[15:0];
      k = 0; busy_cnt = 0; done_at = -1;
      while (k < 40 && done_at < 0) begin
         if (Busy) busy_cnt++;
         if (Done) done_at = k;
         else begin
            @(negedge clk);
            k++;
         end
      end
      $display("[TB] start D1=0x%08h D2=0x%04h done_at=%0d busy_cycles=%0d", d1, d2, done_at, busy_cnt);
      chk("done_latency", 32'(done_at), e.ovf ? 32'd0 : 32'd16);
      chk("busy_cycles", 32'(busy_cnt), e.ovf ? 32'd0 : 32'd16);
   endtask

   initial begin
      int          k, nd, at;
      int          times[4];
      logic [31:0] t, d1;
      logic [15:0] d2, hi;

      #1_000_000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int          k, nd, at;
      int          times[4];
      logic [31:0] t, d1;
      logic [15:0] d2, hi;

      @(posedge clk);
      #1;
      chk("reset_quoc", 32'(quoc), 32'd0);
      chk("reset_rest", 32'(rest), 32'd0);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_done", 32'(Done), 32'd0);
      chk("reset_ovf", 32'(Ovf), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_div(32'd4000000, 16'd2000);
      run_div(32'd1000003, 16'd1000);
      run_div(32'd7, 16'd9);
      run_div(32'h00FF0000, 16'h00FF);
      run_div(32'hFFFEFFFF, 16'hFFFF);
      run_div(32'h00FF0000, 16'h0000);

      // Asynchronous reset in the middle of a calculation.
      @(negedge clk);
      D1 = 32'd4000000; D2 = 16'd2000; St = 1'b1;
      exp_q.push_back(model(32'd4000000, 16'd2000));
      @(negedge clk);
      St = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy_before_reset", 32'(Busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      $display("[TB] async reset mid-CALC quoc=0x%04h rest=0x%04h busy=%0b", quoc, rest, Busy);
      chk("async_rst_quoc", 32'(quoc), 32'd0);
      chk("async_rst_rest", 32'(rest), 32'd0);
      chk("async_rst_busy", 32'(Busy), 32'd0);
      chk("async_rst_done", 32'(Done), 32'd0);
      chk("async_rst_ovf", 32'(Ovf), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      run_div(32'd100, 16'd7);

      // A second start during CALC must be ignored.
      @(negedge clk);
      D1 = 32'd1000003; D2 = 16'd1000; St = 1'b1;
      exp_q.push_back(model(32'd1000003, 16'd1000));
      @(negedge clk);
      St = 1'b0;
      nd = 0; at = -1;
      for (k = 0; k < 30; k++) begin
         if (Done) begin nd++; at = k; end
         if (k == 5) begin St = 1'b1; D1 = 32'd7; D2 = 16'd9; end
         if (k == 6) St = 1'b0;
         @(negedge clk);
      end
      $display("[TB] ignored start: done_count=%0d done_at=%0d", nd, at);
      chk("ignored_st_done_count", 32'(nd), 32'd1);
      chk("ignored_st_latency", 32'(at), 32'd16);

      // St held high: back-to-back divisions.
      for (int i = 0; i < 4; i++) exp_q.push_back(model(32'd100, 16'd7));
      @(negedge clk);
      D1 = 32'd100; D2 = 16'd7; St = 1'b1;
      k = 0; nd = 0;
      while (k < 120 && nd < 4) begin
         if (Done) begin
            times[nd] = k;
            nd++;
            if (nd == 4) St = 1'b0;
         end
         if (nd < 4) begin
            @(negedge clk);
            k++;
         end
      end
      chk("held_st_done_count", 32'(nd), 32'd4);
      for (int i = 1; i < 4; i++) begin
         $display("[TB] held start: done spacing %0d", times[i] - times[i-1]);
         if (i < nd) chk("held_st_spacing", 32'(times[i] - times[i-1]), 32'd18);
      end
      repeat (3) @(negedge clk);

      // Randomized divisions, mostly in range with occasional overflow / zero divisor.
      for (int i = 0; i < 20; i++) begin
         t = $urandom; d2 = t[15:0];
         if (i % 7 == 3) d2 = 16'd0;
         t = $urandom;
         if (d2 != 16'd0) t = t % 32'(d2);
         hi = t[15:0];
         if (i % 5 == 4) begin t = $urandom; hi = t[15:0]; end
         t = $urandom;
         d1 = {hi, t[15:0]};
         run_div(d1, d2);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
